hc595_chain_drv: RTL and testbench



---
 rtl/hc595_chain_drv.sv | 139 +++++++++++++
 tb/tb_hc595_chain_drv.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_chain_drv.sv
// Serial driver for a daisy-chain of 74HC595 shift registers: takes a word over
// valid/ready, shifts it out on ds/shcp at a programmable rate, then pulses stcp.
module hc595_chain_drv #(
    parameter int DATA_W    = 14,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              out_en,
    output logic              busy,
    output logic              done,
    output logic              ds,
    output logic              shcp,
    output logic              stcp,
    output logic              oe_n
);
    localparam int HALF  = CLK_DIV / 2;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF);
    localparam logic [DIV_W-1:0] LAT_LAST = DIV_W'(HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic                armed_q, armed_d;
    logic                data_ready_q, data_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ds_q, ds_d;
    logic                shcp_q, shcp_d;
    logic                stcp_q, stcp_d;
    logic                oe_n_q, oe_n_d;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        armed_d = armed_q | done_q;

        case (state_q)
            IDLE: begin
                if (data_valid && data_ready_q) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    sr_d    = data_in;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = LATCH;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sr_d  = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LATCH: begin
                if (div_q == LAT_LAST) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so every pin comes straight off a flop.
        data_ready_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        ds_d         = (state_d == SHIFT) &&
                       ((MSB_FIRST != 0) ? sr_d[DATA_W-1] : sr_d[0]);
        shcp_d       = (state_d == SHIFT) && (div_d >= DIV_HALF);
        stcp_d       = (state_d == LATCH);
        done_d       = (state_d == LATCH) && (div_d == LAT_LAST);
        // Outputs stay blanked until the chain has been loaded once.
        oe_n_d       = (armed_q || done_q) ? ~out_en : 1'b1;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            sr_q         <= '0;
            armed_q      <= 1'b0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ds_q         <= 1'b0;
            shcp_q       <= 1'b0;
            stcp_q       <= 1'b0;
            oe_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            sr_q         <= sr_d;
            armed_q      <= armed_d;
            data_ready_q <= data_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ds_q         <= ds_d;
            shcp_q       <= shcp_d;
            stcp_q       <= stcp_d;
            oe_n_q       <= oe_n_d;
        end
    end

    assign data_ready = data_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ds         = ds_q;
    assign shcp       = shcp_q;
    assign stcp       = stcp_q;
    assign oe_n       = oe_n_q;
endmodule

// File: tb/tb_hc595_chain_drv.sv
// Directed bench for hc595_chain_drv: default, LSB-first and 16-bit/8-divider
// instances, each followed by a behavioural 74HC595 chain.
module tb_hc595_chain_drv;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic out_en  = 1'b1;

    logic [13:0] d0_in = '0;
    logic        d0_valid = 1'b0;
    logic        d0_ready, d0_busy, d0_done, d0_ds, d0_shcp, d0_stcp, d0_oe_n;
    logic [13:0] d1_in = '0;
    logic        d1_valid = 1'b0;
    logic        d1_ready, d1_busy, d1_done, d1_ds, d1_shcp, d1_stcp, d1_oe_n;
    logic [15:0] d2_in = '0;
    logic        d2_valid = 1'b0;
    logic        d2_ready, d2_busy, d2_done, d2_ds, d2_shcp, d2_stcp, d2_oe_n;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    hc595_chain_drv u0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data_in(d0_in), .data_valid(d0_valid),
        .data_ready(d0_ready), .out_en(out_en), .busy(d0_busy), .done(d0_done),
        .ds(d0_ds), .shcp(d0_shcp), .stcp(d0_stcp), .oe_n(d0_oe_n));

    hc595_chain_drv #(.DATA_W(14), .CLK_DIV(4), .MSB_FIRST(0)) u1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data_in(d1_in), .data_valid(d1_valid),
        .data_ready(d1_ready), .out_en(out_en), .busy(d1_busy), .done(d1_done),
        .ds(d1_ds), .shcp(d1_shcp), .stcp(d1_stcp), .oe_n(d1_oe_n));

    hc595_chain_drv #(.DATA_W(16), .CLK_DIV(8), .MSB_FIRST(1)) u2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data_in(d2_in), .data_valid(d2_valid),
        .data_ready(d2_ready), .out_en(out_en), .busy(d2_busy), .done(d2_done),
        .ds(d2_ds), .shcp(d2_shcp), .stcp(d2_stcp), .oe_n(d2_oe_n));

    // 595 chain models; the LSB-first chain is wired so bit 0 lands in Q0.
    logic [13:0] ch0 = '0, lat0 = '0, ch1 = '0, lat1 = '0;
    logic [15:0] ch2 = '0, lat2 = '0;
    int stcp0_cnt = 0, sh1_cnt = 0, hs0 = 0;

    always @(posedge d0_shcp) ch0 <= {ch0[12:0], d0_ds};
    always @(posedge d0_stcp) begin lat0 <= ch0; stcp0_cnt <= stcp0_cnt + 1; end
    always @(posedge d1_shcp) begin ch1 <= {d1_ds, ch1[13:1]}; sh1_cnt <= sh1_cnt + 1; end
    always @(posedge d1_stcp) lat1 <= ch1;
    always @(posedge d2_shcp) ch2 <= {ch2[14:0], d2_ds};
    always @(posedge d2_stcp) lat2 <= ch2;
    always @(posedge sys_clk) if (d0_valid && d0_ready) hs0 <= hs0 + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start0(input logic [13:0] w);
        d0_in = w;
        d0_valid = 1'b1;
        @(negedge sys_clk);
        d0_valid = 1'b0;
    endtask

    initial begin
        logic [13:0] exp1;
        logic [13:0] exp2;
        logic [15:0] exp5;
        int k, base, s_stcp;
        exp1 = 14'b10101001011100;
        exp2 = 14'b00111010010101;
        exp5 = 16'b1010010101011010;

        // reset values
        repeat (3) @(negedge sys_clk);
        chk("rst_ready", d0_ready, 1'b0);
        chk("rst_busy", d0_busy, 1'b0);
        chk("rst_done", d0_done, 1'b0);
        chk("rst_ds", d0_ds, 1'b0);
        chk("rst_shcp", d0_shcp, 1'b0);
        chk("rst_stcp", d0_stcp, 1'b0);
        chk("rst_oe_n", d0_oe_n, 1'b1);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rel_ready", d0_ready, 1'b1);
        chk("rel_busy", d0_busy, 1'b0);
        chk("rel_oe_n", d0_oe_n, 1'b1);

        // test 1 + 6: MSB-first 2A5C, out_en held high
        start0(14'h2A5C);
        for (int c = 1; c <= 56; c++) begin
            k = (c - 1) / 4;
            chk("t1_ds", d0_ds, exp1[13-k]);
            chk("t1_shcp", d0_shcp, ((c - 1) % 4) >= 2);
            chk("t1_busy", d0_busy, 1'b1);
            chk("t1_ready", d0_ready, 1'b0);
            chk("t1_stcp", d0_stcp, 1'b0);
            chk("t6_oe_n_hold", d0_oe_n, 1'b1);
            @(negedge sys_clk);
        end
        chk("t1_stcp57", d0_stcp, 1'b1);
        chk("t1_done57", d0_done, 1'b0);
        chk("t1_shcp57", d0_shcp, 1'b0);
        chk("t1_ds57", d0_ds, 1'b0);
        @(negedge sys_clk);
        chk("t1_stcp58", d0_stcp, 1'b1);
        chk("t1_done58", d0_done, 1'b1);
        chk("t6_oe_n58", d0_oe_n, 1'b1);
        @(negedge sys_clk);
        chk("t1_stcp59", d0_stcp, 1'b0);
        chk("t1_done59", d0_done, 1'b0);
        chk("t1_ready59", d0_ready, 1'b1);
        chk("t1_busy59", d0_busy, 1'b0);
        chk("t1_latch", lat0, 14'h2A5C);
        chk("t1_stcp_edges", stcp0_cnt, 1);
        chk("t6_oe_n59", d0_oe_n, 1'b0);
        out_en = 1'b0;
        chk("t6_oe_n_lat", d0_oe_n, 1'b0);
        @(negedge sys_clk);
        chk("t6_oe_n_off", d0_oe_n, 1'b1);
        out_en = 1'b1;
        @(negedge sys_clk);
        chk("t6_oe_n_on", d0_oe_n, 1'b0);

        // test 3: back-to-back with data_valid held high
        base = hs0;
        d0_in = 14'h3FFF;
        d0_valid = 1'b1;
        @(negedge sys_clk);
        d0_in = 14'h0001;
        repeat (57) @(negedge sys_clk);
        chk("t3_ready58", d0_ready, 1'b0);
        chk("t3_done58", d0_done, 1'b1);
        chk("t3_hs_busy", hs0 - base, 1);
        @(negedge sys_clk);
        chk("t3_ready59", d0_ready, 1'b1);
        chk("t3_latch1", lat0, 14'h3FFF);
        @(negedge sys_clk);
        chk("t3_ready60", d0_ready, 1'b0);
        chk("t3_busy60", d0_busy, 1'b1);
        chk("t3_hs2", hs0 - base, 2);
        repeat (58) @(negedge sys_clk);
        d0_valid = 1'b0;
        chk("t3_ready_end", d0_ready, 1'b1);
        chk("t3_latch2", lat0, 14'h0001);
        @(negedge sys_clk);
        chk("t3_idle", d0_ready, 1'b1);
        chk("t3_hs_total", hs0 - base, 2);

        // test 4: reset during bit 5
        start0(14'h1555);
        repeat (21) @(negedge sys_clk);
        chk("t4_busy_pre", d0_busy, 1'b1);
        s_stcp = stcp0_cnt;
        sys_rst = 1'b1;
        #1;
        chk("t4_ready", d0_ready, 1'b0);
        chk("t4_busy", d0_busy, 1'b0);
        chk("t4_done", d0_done, 1'b0);
        chk("t4_ds", d0_ds, 1'b0);
        chk("t4_shcp", d0_shcp, 1'b0);
        chk("t4_stcp", d0_stcp, 1'b0);
        chk("t4_oe_n", d0_oe_n, 1'b1);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("t4_rel_ready", d0_ready, 1'b1);
        chk("t4_rel_oe_n", d0_oe_n, 1'b1);
        chk("t4_no_stcp", stcp0_cnt - s_stcp, 0);
        start0(14'h1234);
        repeat (57) @(negedge sys_clk);
        chk("t4_done", d0_done, 1'b1);
        chk("t4_oe_n_armed", d0_oe_n, 1'b1);
        @(negedge sys_clk);
        chk("t4_latch", lat0, 14'h1234);
        chk("t4_oe_n_after", d0_oe_n, 1'b0);
        chk("t4_ready_after", d0_ready, 1'b1);

        // test 2: LSB-first
        base = sh1_cnt;
        d1_in = 14'h2A5C;
        d1_valid = 1'b1;
        @(negedge sys_clk);
        d1_valid = 1'b0;
        d1_in = 14'h0000;
        for (int c = 1; c <= 56; c++) begin
            k = (c - 1) / 4;
            chk("t2_ds", d1_ds, exp2[13-k]);
            chk("t2_busy", d1_busy, 1'b1);
            @(negedge sys_clk);
        end
        chk("t2_stcp57", d1_stcp, 1'b1);
        @(negedge sys_clk);
        chk("t2_done58", d1_done, 1'b1);
        @(negedge sys_clk);
        chk("t2_edges", sh1_cnt - base, 14);
        chk("t2_latch", lat1, 14'h2A5C);
        chk("t2_ready", d1_ready, 1'b1);
        chk("t2_oe_n", d1_oe_n, 1'b0);

        // test 5: 16 bits, divider 8
        d2_in = 16'hA55A;
        d2_valid = 1'b1;
        @(negedge sys_clk);
        d2_valid = 1'b0;
        for (int c = 1; c <= 128; c++) begin
            k = (c - 1) / 8;
            chk("t5_ds", d2_ds, exp5[15-k]);
            chk("t5_shcp", d2_shcp, ((c - 1) % 8) >= 4);
            chk("t5_stcp", d2_stcp, 1'b0);
            chk("t5_busy", d2_busy, 1'b1);
            @(negedge sys_clk);
        end
        for (int c = 129; c <= 132; c++) begin
            chk("t5_stcp_hi", d2_stcp, 1'b1);
            chk("t5_done", d2_done, c == 132);
            chk("t5_shcp_lo", d2_shcp, 1'b0);
            @(negedge sys_clk);
        end
        chk("t5_stcp133", d2_stcp, 1'b0);
        chk("t5_ready133", d2_ready, 1'b1);
        chk("t5_latch", lat2, 16'hA55A);
        chk("t5_oe_n", d2_oe_n, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
